jtopl_lfo: RTL

Low-frequency oscillator for the OPL2 core: one tremolo (AM) triangle and one vibrato phase counter, both advanced once per sample frame. It sits directly upstream of the envelope generator and phase generator. It drives the envelope generator's 4-bit `lfo_mod` input, which is gated there by `amsen`/`ams`, and the phase generator's 3-bit vibrato phase. Timing is taken from the same `cenop`/`zero` strobes as the slot pipeline.

---
 rtl/jtopl_pkg.sv | 13 +
 rtl/jtopl_lfo.sv | 87 ++++++++
 2 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL2 core: LFO prescaler widths and AM triangle period.
package jtopl_pkg;

    // AM triangle period in positions (must be even and no larger than 128).
    localparam int JTOPL_AM_STEPS    = 104;
    // AM position advances every 2^JTOPL_AM_PRESC_W frames.
    localparam int JTOPL_AM_PRESC_W  = 7;
    // Vibrato phase advances every 2^JTOPL_VIB_PRESC_W frames.
    localparam int JTOPL_VIB_PRESC_W = 10;
    // Number of positions on the rising half of the AM triangle.
    localparam int JTOPL_AM_HALF     = JTOPL_AM_STEPS / 2;

endpackage

// File: rtl/jtopl_lfo.sv
// OPL2 low-frequency oscillator: tremolo (AM) triangle level and vibrato phase,
// both advanced once per sample frame on the cenop-qualified zero strobe.
module jtopl_lfo
    import jtopl_pkg::*;
#(
    parameter int AM_PRESC_W  = JTOPL_AM_PRESC_W,
    parameter int VIB_PRESC_W = JTOPL_VIB_PRESC_W,
    parameter int AM_STEPS    = JTOPL_AM_STEPS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic       zero,
    input  logic       lfo_rst,
    output logic [3:0] lfo_mod,
    output logic [2:0] vib_pos,
    output logic       am_top
);

    localparam int AM_HALF = AM_STEPS / 2;

    logic [VIB_PRESC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [6:0]             am_pos_q,    am_pos_d;
    logic [2:0]             vib_pos_q,   vib_pos_d;
    logic [3:0]             lfo_mod_q,   lfo_mod_d;
    logic                   am_top_q,    am_top_d;

    logic       advance;
    logic       am_tick;
    logic       vib_tick;
    logic [6:0] am_tri;

    // Next-state: test reset beats the frame strobe; otherwise step the
    // prescaler and the two LFO positions, then fold the AM position.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        frame_cnt_d = frame_cnt_q;
        am_pos_d    = am_pos_q;
        vib_pos_d   = vib_pos_q;

        advance  = cenop && zero && !lfo_rst;
        am_tick  = &frame_cnt_q[AM_PRESC_W-1:0];
        vib_tick = &frame_cnt_q;

        if (cenop && lfo_rst) begin
            frame_cnt_d = '0;
            am_pos_d    = '0;
            vib_pos_d   = '0;
        end else if (advance) begin
            frame_cnt_d = frame_cnt_q + VIB_PRESC_W'(1);
            if (am_tick) begin
                am_pos_d = (am_pos_q == 7'(AM_STEPS - 1)) ? 7'd0 : am_pos_q + 7'd1;
            end
            if (vib_tick) begin
                vib_pos_d = vib_pos_q + 3'd1;
            end
        end

        // Outputs follow the next position so they switch on the same edge.
        am_tri    = (am_pos_d < 7'(AM_HALF)) ? am_pos_d : 7'(AM_STEPS - 1) - am_pos_d;
        lfo_mod_d = 4'(am_tri >> 2);
        am_top_d  = (am_pos_d >= 7'(AM_HALF));
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            am_pos_q    <= '0;
            vib_pos_q   <= '0;
            lfo_mod_q   <= '0;
            am_top_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            frame_cnt_q <= frame_cnt_d;
            am_pos_q    <= am_pos_d;
            vib_pos_q   <= vib_pos_d;
            lfo_mod_q   <= lfo_mod_d;
            am_top_q    <= am_top_d;
        end
    end

    assign lfo_mod = lfo_mod_q;
    assign vib_pos = vib_pos_q;
    assign am_top  = am_top_q;

endmodule
